acc_stage: RTL and testbench

ACC_STAGE -- requirements
Module: acc_stage

---
 rtl/acc_stage.sv | 92 +++++++++
 tb/tb_acc_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_stage.sv
// Burst accumulator stage: loads the first beat, then accumulates subsequent beats
// through an external adder and presents the result with sticky carry/overflow flags.
module acc_stage #(
  parameter int size  = 4,
  parameter int cnt_w = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [size-1:0]  in_data,
  input  logic             in_last,
  output logic [size-1:0]  add_a,
  output logic [size-1:0]  add_b,
  input  logic [size-1:0]  add_sum,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [size-1:0]  out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [cnt_w-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [size-1:0]  acc;
  logic             carry;
  logic             ovf;
  logic [cnt_w-1:0] count;
  logic             beat;

  // Beat counter pins at all-ones instead of wrapping on very long bursts.
  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign beat      = in_valid && in_ready;

  assign add_a = acc;
  assign add_b = in_data;

  assign out_data  = acc;
  assign out_carry = carry;
  assign out_ovf   = ovf;
  assign out_zero  = (acc == '0);
  assign out_neg   = acc[size-1];
  assign out_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc   <= in_data;
            carry <= 1'b0;
            ovf   <= 1'b0;
            count <= {{(cnt_w-1){1'b0}}, 1'b1};
            state <= in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= add_sum;
            carry <= carry | add_cout;
            ovf   <= ovf | add_ovf;
            count <= sat_inc(count);
            state <= in_last ? DONE : ACCUM;
          end
        end
        DONE: begin
          // Result and flags stay visible until the next burst loads.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_stage.sv
// Bench for acc_stage: directed bursts plus random bursts, checked by a scoreboard monitor.
module tb_acc_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_data;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cout, add_ovf;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic       out_carry, out_ovf, out_zero, out_neg;
  logic [7:0] out_count;
  logic [4:0] s5;

  always #5 clk = ~clk;

  // Behavioural adder the stage drives.
  assign s5       = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum  = s5[3:0];
  assign add_cout = s5[4];
  assign add_ovf  = (add_a[3] == add_b[3]) && (s5[3] != add_a[3]);

  acc_stage #(.size(4), .cnt_w(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
    .out_count(out_count)
  );

  typedef struct {
    logic [3:0] d;
    logic       c, o, z, n;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [3:0] d, input logic c, input logic o, input logic [7:0] cnt);
    exp_t e;
    e.d = d; e.c = c; e.o = o; e.z = (d == 4'h0); e.n = d[3]; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Monitor: compares each newly presented result against the scoreboard.
  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) seen = 0;
      else if (out_valid && !seen) begin
        seen = 1;
        if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("out_data",  32'(out_data),  32'(e.d));
          chk("out_carry", 32'(out_carry), 32'(e.c));
          chk("out_ovf",   32'(out_ovf),   32'(e.o));
          chk("out_zero",  32'(out_zero),  32'(e.z));
          chk("out_neg",   32'(out_neg),   32'(e.n));
          chk("out_count", 32'(out_count), 32'(e.cnt));
        end
      end else if (!out_valid) seen = 0;
    end
  end

  // All stimulus runs at posedge+1.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [3:0] d, input logic last);
    bit ok;
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 50 && !done; i++) begin
      ok = in_ready;
      step();
      if (ok) done = 1;
    end
    if (!done) chk("beat_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
    if (last) chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic retire(input int stall);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1;
      else step();
    end
    if (!got) chk("out_valid_timeout", 32'd0, 32'd1);
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_retire", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] acc_m, d;
    logic       c_m, o_m;
    logic [4:0] s;
    logic [7:0] cnt_m;
    int         len;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_zero",  32'(out_zero),  32'd1);
    chk("rst_out_neg",   32'(out_neg),   32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Single beat.
    push_exp(4'h5, 0, 0, 8'd1);
    send_beat(4'h5, 1);
    retire(0);

    // 7 + 1 overflows into the sign bit.
    push_exp(4'h8, 0, 1, 8'd2);
    send_beat(4'h7, 0); send_beat(4'h1, 1);
    retire(1);

    // F + 1 wraps with carry; next burst clears flags.
    push_exp(4'h0, 1, 0, 8'd2);
    send_beat(4'hF, 0); send_beat(4'h1, 1);
    retire(0);
    push_exp(4'h7, 0, 0, 8'd2);
    send_beat(4'h3, 0); send_beat(4'h4, 1);
    retire(2);

    // Hold in DONE with in_valid asserted: nothing may change.
    push_exp(4'h9, 0, 0, 8'd1);
    send_beat(4'h9, 1);
    in_valid = 1'b1; in_data = 4'h3; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_out_data",  32'(out_data),  32'h9);
      chk("hold_out_count", 32'(out_count), 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_in_ready",  32'(in_ready),  32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_out_data",  32'(out_data),  32'h9);

    // Reset mid-burst, between clock edges.
    send_beat(4'h2, 0); send_beat(4'h3, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data",  32'(out_data),  32'd0);
    chk("midrst_out_zero",  32'(out_zero),  32'd1);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    #2 rst_n = 1'b1;
    step();
    push_exp(4'h6, 0, 0, 8'd1);
    send_beat(4'h6, 1);
    retire(0);

    // Random bursts against a reference model.
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        d = 4'($urandom_range(0, 15));
        if (k == 0) begin
          acc_m = d; c_m = 0; o_m = 0; cnt_m = 8'd1;
        end else begin
          s = {1'b0, acc_m} + {1'b0, d};
          c_m = c_m | s[4];
          o_m = o_m | ((acc_m[3] == d[3]) && (s[3] != acc_m[3]));
          acc_m = s[3:0];
          cnt_m = cnt_m + 8'd1;
        end
        if (k == len - 1) push_exp(acc_m, c_m, o_m, cnt_m);
        repeat ($urandom_range(0, 2)) step();
        send_beat(d, (k == len - 1));
      end
      retire($urandom_range(0, 3));
    end

    repeat (2) step();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
